// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the byte-serial main-memory port between the
// instruction cache (requester 0) and the data cache (requester 1).
module mem_port_arbiter #(
  parameter int unsigned AWIDTH  = 16,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c0_rd,
  input  logic              c1_rd,
  input  logic              c0_wr,
  input  logic              c1_wr,
  input  logic [AWIDTH-1:0] c0_addr,
  input  logic [AWIDTH-1:0] c1_addr,
  input  logic [DWIDTH-1:0] c0_wdata,
  input  logic [DWIDTH-1:0] c1_wdata,
  output logic [DWIDTH-1:0] c_rdata,
  output logic              c0_beat,
  output logic              c1_beat,
  output logic              c0_done,
  output logic              c1_done,
  output logic              c0_err,
  output logic              c1_err,
  output logic [AWIDTH-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DWIDTH-1:0] wdata_mem,
  input  logic [DWIDTH-1:0] rdata_mem,
  input  logic              ready_mem,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LO, WAIT_HI, XFER, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              rd_mem_q, rd_mem_d;
  logic              wr_mem_q, wr_mem_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, busy_d;

  logic              req0, req1, win1, win_rd;
  logic [AWIDTH-1:0] win_addr;

  assign req0 = c0_rd | c0_wr;
  assign req1 = c1_rd | c1_wr;

  // Next-state and registered-output logic; outputs reflect the state being entered.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    rd_mem_d = 1'b0;
    wr_mem_d = 1'b0;
    beat_d   = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    win1     = req1 & (~req0 | ptr_q);
    win_rd   = win1 ? c1_rd : c0_rd;
    win_addr = win1 ? c1_addr : c0_addr;

    case (state_q)
      IDLE: begin
        if ((req0 | req1) && ready_mem) begin
          grant_d  = win1 ? 2'b10 : 2'b01;
          addr_d   = win_addr & ~AWIDTH'(3);
          rd_mem_d = win_rd;
          wr_mem_d = ~win_rd;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ready_mem) begin
          state_d = WAIT_HI;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TW'(TIMEOUT)) begin
            state_d = DONE;
            done_d  = grant_q;
            err_d   = grant_q;
          end
        end
      end
      WAIT_HI: begin
        if (ready_mem) begin
          bcnt_d  = '0;
          beat_d  = grant_q;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bcnt_q == BW'(BEATS - 1)) begin
          done_d  = grant_q;
          state_d = DONE;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
          beat_d = grant_q;
        end
      end
      DONE: begin
        ptr_d   = grant_q[0];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 2'b00;
      addr_q   <= '0;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      beat_q   <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      rd_mem_q <= rd_mem_d;
      wr_mem_q <= wr_mem_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Write byte follows the owner's current beat data; zero while nobody owns the port.
  always_comb begin
    wdata_mem = '0;
    if (grant_q[0])      wdata_mem = c0_wdata;
    else if (grant_q[1]) wdata_mem = c1_wdata;
  end

  assign c_rdata  = rdata_mem;
  assign addr_mem = addr_q;
  assign rd_mem   = rd_mem_q;
  assign wr_mem   = wr_mem_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign c0_beat  = beat_q[0];
  assign c1_beat  = beat_q[1];
  assign c0_done  = done_q[0];
  assign c1_done  = done_q[1];
  assign c0_err   = err_q[0];
  assign c1_err   = err_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// issue/beat/done events; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NB = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          c0_rd = 1'b0, c1_rd = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c0_beat, c1_beat, c0_done, c1_done, c0_err, c1_err;
  logic [AW-1:0] addr_mem;
  logic          rd_mem, wr_mem;
  logic [DW-1:0] wdata_mem;
  logic [DW-1:0] rdata_mem = '0;
  logic          ready_mem;
  logic [1:0]    grant;
  logic          busy;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BEATS(NB), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .c0_rd(c0_rd), .c1_rd(c1_rd), .c0_wr(c0_wr), .c1_wr(c1_wr),
    .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c_rdata(c_rdata),
    .c0_beat(c0_beat), .c1_beat(c1_beat), .c0_done(c0_done), .c1_done(c1_done),
    .c0_err(c0_err), .c1_err(c1_err), .addr_mem(addr_mem),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem), .ready_mem(ready_mem), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;   // 0 issue, 1 beat, 2 done
    int          who;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, issue_cyc = 0, done_cyc = 0, last_done_cyc = -1;
  bit         gap_check = 0;
  logic [7:0] rbytes [NB] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] w0     [NB] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
  logic [7:0] w1     [NB] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  // Memory model state
  logic mem_rdy = 1'b1;
  bit   force_lo = 0, to_mode = 0;
  int   hold = 0, bk = 0;
  assign ready_mem = mem_rdy & ~force_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input int who, input logic wr, input logic [15:0] addr, input logic err);
    exp_t e;
    e.kind = 0; e.who = who; e.wr = wr; e.addr = addr & 16'hFFFC; e.data = '0; e.err = 1'b0;
    sb.push_back(e);
    if (!err) begin
      for (int k = 0; k < NB; k++) begin
        e.kind = 1;
        e.data = wr ? ((who == 1) ? w1[k] : w0[k]) : rbytes[k];
        sb.push_back(e);
      end
    end
    e.kind = 2; e.err = err;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory model: drops ready one cycle after the strobe, low for 4 cycles, then streams bytes.
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset_n) begin
      mem_rdy = 1'b1; hold = 0; bk = 0; rdata_mem = '0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) mem_rdy = 1'b1;
      end
      if ((rd_mem | wr_mem) && !to_mode) begin
        mem_rdy = 1'b0;
        hold = 4;
      end
      if ((c0_beat | c1_beat) && bk < NB) begin
        rdata_mem = rbytes[bk];
        if (c0_beat) c0_wdata = w0[bk];
        if (c1_beat) c1_wdata = w1[bk];
        bk++;
      end else begin
        rdata_mem = '0;
      end
      if (c0_done | c1_done) bk = 0;
    end
  end

  // Monitor: pops one expected event per issue/beat/done cycle.
  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      if (grant == 2'b00) check("wdata_zero_when_idle", 32'(wdata_mem), 32'h0);
      check("err_only_with_done", 32'({c1_err & ~c1_done, c0_err & ~c0_done}), 32'h0);
      if (rd_mem | wr_mem | c0_beat | c1_beat | c0_done | c1_done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: got rd=%0b wr=%0b beat=%0b%0b done=%0b%0b expected none (cycle %0d)",
                   rd_mem, wr_mem, c1_beat, c0_beat, c1_done, c0_done, cyc);
        end else begin
          exp_t e;
          logic [1:0] oh;
          int kind;
          e = sb.pop_front();
          oh = (e.who == 1) ? 2'b10 : 2'b01;
          kind = (rd_mem | wr_mem) ? 0 : (c0_beat | c1_beat) ? 1 : 2;
          check("event_kind", 32'(kind), 32'(e.kind));
          if (kind == 0) begin
            check("issue_grant", 32'(grant), 32'(oh));
            check("issue_strobe", 32'({wr_mem, rd_mem}), e.wr ? 32'h2 : 32'h1);
            check("issue_addr", 32'(addr_mem), 32'(e.addr));
            if (gap_check && last_done_cyc >= 0) check("issue_gap", 32'(cyc - last_done_cyc), 32'd2);
            issue_cyc = cyc;
          end else if (kind == 1) begin
            check("beat_owner", 32'({c1_beat, c0_beat}), 32'(oh));
            check("beat_addr", 32'(addr_mem), 32'(e.addr));
            check(e.wr ? "beat_wdata" : "beat_rdata", 32'(e.wr ? wdata_mem : c_rdata), 32'(e.data));
          end else begin
            check("done_owner", 32'({c1_done, c0_done}), 32'(oh));
            check("done_err", 32'({c1_err, c0_err}), e.err ? 32'(oh) : 32'h0);
            done_cyc = cyc;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_dones(input int n0, input int n1);
    int r0 = n0, r1 = n1, budget = 400;
    while ((r0 > 0 || r1 > 0) && budget > 0) begin
      @(posedge clock); #2;
      budget--;
      if (c0_done && r0 > 0) begin r0--; if (r0 == 0) begin c0_rd = 1'b0; c0_wr = 1'b0; end end
      if (c1_done && r1 > 0) begin r1--; if (r1 == 0) begin c1_rd = 1'b0; c1_wr = 1'b0; end end
    end
    if (budget == 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_wait_timeout: got %0d/%0d dones outstanding expected 0", r0, r1);
      c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
    end
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    last_done_cyc = -1;
    @(posedge clock); #2;
  endtask

  initial begin
    int nb;
    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addr", 32'(addr_mem), 32'h0);
    check("rst_strobes", 32'({rd_mem, wr_mem}), 32'h0);
    check("rst_beat_done_err", 32'({c0_beat, c1_beat, c0_done, c1_done, c0_err, c1_err}), 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #2;

    // Single read from c0; issue to done is ISSUE+WAIT_LO+3 WAIT_HI+4 XFER = 9 cycles
    push_txn(0, 1'b0, 16'h00C3, 1'b0);
    c0_addr = 16'h00C3; c0_rd = 1'b1;
    wait_dones(1, 0);
    check("t2_issue_to_done", 32'(done_cyc - issue_cyc), 32'd9);

    // Write from c1
    push_txn(1, 1'b1, 16'hC11A, 1'b0);
    c1_addr = 16'hC11A; c1_wr = 1'b1;
    wait_dones(0, 1);

    // Simultaneous requests from reset alternate c0, c1, c0, c1 with a one-cycle idle gap
    do_reset();
    gap_check = 1;
    push_txn(0, 1'b0, 16'h1235, 1'b0);
    push_txn(1, 1'b1, 16'hBEEF, 1'b0);
    push_txn(0, 1'b0, 16'h1235, 1'b0);
    push_txn(1, 1'b1, 16'hBEEF, 1'b0);
    c0_addr = 16'h1235; c1_addr = 16'hBEEF;
    c0_rd = 1'b1; c1_wr = 1'b1;
    wait_dones(2, 2);
    gap_check = 0;

    // Timeout: ready never drops; done+err 16 cycles after the issue strobe
    to_mode = 1;
    push_txn(0, 1'b0, 16'h4007, 1'b1);
    c0_addr = 16'h4007; c0_rd = 1'b1;
    wait_dones(1, 0);
    to_mode = 0;
    check("t5_timeout_len", 32'(done_cyc - issue_cyc), 32'd16);

    // Pointer flipped by the timed-out c0 transaction: c1 now wins a tie
    push_txn(1, 1'b0, 16'h2222, 1'b0);
    push_txn(0, 1'b1, 16'h3333, 1'b0);
    c0_addr = 16'h3333; c1_addr = 16'h2222;
    c0_wr = 1'b1; c1_rd = 1'b1;
    wait_dones(1, 1);

    // Memory not ready: no arbitration until ready rises; strobe in the 2nd ready-high cycle
    force_lo = 1;
    push_txn(0, 1'b0, 16'h0F0F, 1'b0);
    c0_addr = 16'h0F0F; c0_rd = 1'b1;
    repeat (5) begin
      @(posedge clock); #2;
      check("t6_grant_idle", 32'(grant), 32'h0);
      check("t6_no_strobe", 32'(rd_mem), 32'h0);
    end
    force_lo = 0;
    @(posedge clock); #2;
    check("t6_strobe_after_ready", 32'(rd_mem), 32'h1);
    wait_dones(1, 0);

    // Reset mid-XFER on beat 2: outputs clear at once, no done afterwards
    push_txn(0, 1'b0, 16'h0042, 1'b0);
    repeat (3) void'(sb.pop_back());   // only issue and beats 0,1 will be observed
    c0_addr = 16'h0042; c0_rd = 1'b1;
    nb = 0;
    for (int i = 0; i < 100 && nb < 3; i++) begin
      @(posedge clock); #2;
      if (c0_beat) nb++;
    end
    check("t1_reached_beat2", 32'(nb), 32'd3);
    reset_n = 1'b0;
    c0_rd = 1'b0;
    #1;
    check("t1_rst_grant", 32'(grant), 32'h0);
    check("t1_rst_busy", 32'(busy), 32'h0);
    check("t1_rst_addr", 32'(addr_mem), 32'h0);
    check("t1_rst_beat_done", 32'({c0_beat, c1_beat, c0_done, c1_done, c0_err, c1_err}), 32'h0);
    check("t1_rst_wdata", 32'(wdata_mem), 32'h0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clock); #2;
      check("t1_post_grant", 32'(grant), 32'h0);
      check("t1_post_no_done", 32'({c1_done, c0_done}), 32'h0);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-serial main-memory port between two cache controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Arbitrates between them round-robin and sequences each memory transaction: issue strobe, busy handshake on ready_mem, then a BEATS-long byte transfer.
- Reports completion, or timeout, back to the requester that owns the transaction.
- Sits between the caches and the memory controller.

Parameters:
- AWIDTH, 16, address width.
- DWIDTH, 8, data byte width.
- BEATS, 4, bytes per block transfer (must be at least 1).
- TIMEOUT, 15, maximum cycles to wait for ready_mem to fall after issue.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- c0_rd, c1_rd  in  1  read request; a level held until the matching cN_done
- c0_wr, c1_wr  in  1  write request; a level held until the matching cN_done
- c0_addr, c1_addr  in  AWIDTH  block address; bits [1:0] are ignored (forced to 0 on addr_mem)
- c0_wdata, c1_wdata  in  DWIDTH  write byte for the current beat
- cN_rdata  out  DWIDTH  read byte, shared by both requesters; equals rdata_mem
- c0_beat, c1_beat  out  1  high during each transfer beat of the owned transaction
- c0_done, c1_done  out  1  one-cycle completion pulse
- c0_err, c1_err  out  1  one-cycle pulse coincident with done when the transaction timed out
- addr_mem  out  AWIDTH  memory address
- rd_mem, wr_mem  out  1  one-cycle issue strobes
- wdata_mem  out  DWIDTH  write byte to memory
- rdata_mem  in  DWIDTH  read byte from memory
- ready_mem  in  1  high = memory idle or beat valid
- grant  out  2  one-hot owner; 00 when idle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous):
  - state = IDLE, round-robin pointer = 0.
  - All outputs 0, including addr_mem, grant, strobes, done, err and beat.
  - Beat and timeout counters cleared.
  - Reset mid-transaction aborts immediately with no done pulse. The requester must re-request.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, XFER, DONE.
- IDLE:
  - reqN = cN_rd | cN_wr.
  - If any reqN is high and ready_mem = 1:
    - Only one requesting: that one wins.
    - Both requesting: the pointer's requester wins.
    - Latch the winner's addr with [1:0] = 0, its rd/wr (rd wins if both are high), and grant. Go to ISSUE.
  - If ready_mem = 0: stay in IDLE.
- ISSUE:
  - Drive rd_mem or wr_mem = 1 for exactly this one cycle, with addr_mem valid.
  - Clear the timeout counter. Go to WAIT_LO.
  - addr_mem holds until the next grant.
- WAIT_LO:
  - ready_mem = 0: go to WAIT_HI.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to DONE with the error flag set.
- WAIT_HI:
  - Wait with no limit for ready_mem = 1, then go to XFER with beat counter = 0.
- XFER:
  - Stays exactly BEATS cycles. cN_beat = 1 for the owner on every one of those cycles.
  - Reads: the requester samples cN_rdata on each beat cycle.
  - Writes: wdata_mem = owner's wdata, combinationally muxed by grant; the owner presents byte k on beat k.
  - ready_mem is ignored during XFER.
  - After beat BEATS-1, go to DONE.
- DONE:
  - Pulse the owner's cN_done for one cycle, plus cN_err if timed out.
  - Pointer = the other requester (flipped after every completion, including errors).
  - grant = 00. Go to IDLE.
  - The next arbitration is possible in the following IDLE cycle.
- Requesters:
  - A request dropped before grant is simply not served.
  - A request dropped after grant is ignored; the transaction completes.
  - The non-owner's beat, done and err stay 0 throughout.
- Minimum transaction length is 1 + 1 + 1 + 1 + BEATS + 1 cycles (IDLE, ISSUE, WAIT_LO, WAIT_HI, XFER, DONE).
- wdata_mem = 0 whenever grant = 00.

Test Plan:
1. Reset mid-XFER:
   - Stimulus: assert reset_n = 0 on beat 2.
   - Required: all outputs 0 immediately; after release, grant = 00 and no done pulse.
2. Single read from c0:
   - Stimulus: c0_rd = 1, c0_addr = 16'h00C3; memory drops ready 1 cycle after rd_mem, holds it low 4 cycles, then supplies 11, 22, 33, 44.
   - Required: addr_mem = 16'h00C0; rd_mem high 1 cycle; c0_beat high 4 cycles aligned with those bytes; c0_done 1 cycle later; c1_* stay 0.
3. Write from c1:
   - Stimulus: c1_wr = 1, addr = 16'hC11A; c1_wdata = AA, BB, CC, DD on successive beats.
   - Required: addr_mem = 16'hC118; wr_mem pulse; wdata_mem = AA, BB, CC, DD on the beat cycles; c1_done pulse.
4. Simultaneous requests:
   - Stimulus: both request from reset.
   - Required: c0 served first, then c1 without an idle gap beyond 1 cycle; with both still requesting, the order alternates c0, c1, c0, c1 over 4 transactions.
5. Timeout:
   - Stimulus: ready_mem stays 1 after issue.
   - Required: after 15 WAIT_LO cycles, c0_done and c0_err pulse together; pointer flips; no beats occur.
6. Memory not ready:
   - Stimulus: ready_mem = 0 while c0_rd = 1.
   - Required: no rd_mem and grant stays 00 until ready_mem rises; issue occurs 2 cycles after ready_mem rises.
